axi4_slave_wr_ctrl: RTL and testbench
=====================================

AXI4_SLAVE_WR_CTRL -- requirements
Module: axi4_slave_wr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, byte address width of awaddr and mem_addr.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, write data width; DATA_WIDTH/8 strobe bits.
REQ-003 The block SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port areset, input, 1, the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have AW inputs awid 4, awaddr ADDRESS_WIDTH, awlen 4, awsize 3, awburst 2 and awvalid 1, plus output awready 1.
REQ-006 The block SHALL have W inputs wdata DATA_WIDTH, wstrb DATA_WIDTH/8, wlast 1 and wvalid 1, plus output wready 1.
REQ-007 The block SHALL have B outputs bid 4, bresp 2 and bvalid 1, plus input bready 1.
REQ-008 The block SHALL have memory-port outputs mem_we 1, mem_addr ADDRESS_WIDTH, mem_wdata DATA_WIDTH and mem_wstrb DATA_WIDTH/8.

Function
REQ-009 The block SHALL implement the FSM states IDLE, DATA and RESP.
REQ-010 In IDLE, awready SHALL be 1; an AW handshake (awvalid&&awready) SHALL capture awid, awaddr, awlen, awsize and awburst, load beat counter = awlen, and enter DATA the next cycle.
REQ-011 In DATA, wready SHALL be 1 and awready SHALL be 0.
REQ-012 On each W handshake, mem_we SHALL be 1 in the same cycle (combinational), with mem_addr = current beat address, mem_wdata = wdata and mem_wstrb = wstrb; otherwise mem_we SHALL be 0.
REQ-013 Beat address for FIXED (2'b00) SHALL stay at awaddr for every beat.
REQ-014 Beat address for INCR (2'b01) SHALL advance by (1<<awsize) per beat, wrapping modulo 2^ADDRESS_WIDTH.
REQ-015 Beat address for WRAP (2'b10) SHALL advance by (1<<awsize) within the region of size (awlen+1)*(1<<awsize) aligned to that size, returning to the region base on crossing its upper bound.
REQ-016 Reserved burst 2'b11 SHALL be treated as INCR for addressing.
REQ-017 The burst SHALL be exactly awlen+1 beats (1..16) as counted; wlast SHALL NOT terminate or extend the burst.
REQ-018 After the counted last beat handshake, the FSM SHALL enter RESP on the next cycle.
REQ-019 In RESP, bvalid SHALL be 1, bid SHALL equal the captured awid, and bresp SHALL be held stable until bready.
REQ-020 The B handshake SHALL return the FSM to IDLE (awready=1 next cycle); bvalid SHALL be deasserted in that same next cycle.
REQ-021 Minimum AW-to-AW spacing SHALL be awlen+3 cycles; the block SHALL handle one outstanding transaction only.
REQ-022 An AW or W handshake in a state where the ready is 0 SHALL be impossible; W activity in IDLE/RESP SHALL be ignored.

Reset
REQ-023 While areset=1, all outputs SHALL be forced immediately to: awready 0, wready 0, bvalid 0, bid 0, bresp 2'b00, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0; the FSM SHALL be in IDLE.
REQ-024 On the first aclk edge after areset deasserts, awready SHALL become 1.
REQ-025 Reset mid-burst SHALL abandon the transaction, with no B response issued.

Configuration
REQ-026 Macro AXI4_WR_ERR_CHECK_EN SHALL control protocol error checking.
REQ-027 When AXI4_WR_ERR_CHECK_EN is defined, a sticky error flag SHALL be set by any of: wlast=1 on a non-final beat, wlast=0 on the final beat, awburst=2'b11, or (1<<awsize) > DATA_WIDTH/8.
REQ-028 When AXI4_WR_ERR_CHECK_EN is defined, the flag SHALL give bresp=2'b10 (SLVERR), else 2'b00; the flag SHALL clear on the AW handshake; memory writes SHALL still occur.
REQ-029 When AXI4_WR_ERR_CHECK_EN is undefined, bresp SHALL always be 2'b00 and no checking logic SHALL exist.

Verification
REQ-030 Single beat INCR: awid=3, awaddr=0x100, awlen=0, awsize=2, wlast=1 -> one mem_we at 0x100; then bvalid with bid=3 and bresp=00.
REQ-031 INCR 4 beats: awaddr=0x1000, awsize=2, awlen=3 -> mem_addr 0x1000, 0x1004, 0x1008, 0x100C.
REQ-032 WRAP 4 beats: awaddr=0x1008, awsize=2, awlen=3 -> mem_addr 0x1008, 0x100C, 0x1000, 0x1004.
REQ-033 FIXED with backpressure: awaddr=0x40, awlen=2, wvalid toggled every other cycle, bready held 0 for 5 cycles -> three writes at 0x40; bvalid stable for 5 cycles; IDLE one cycle after bready.
REQ-034 With AXI4_WR_ERR_CHECK_EN, awlen=3 and wlast on beat 2 -> 4 writes, bresp=10; the next clean burst gives bresp=00.
REQ-035 areset asserted during beat 2 of awlen=7 -> outputs zero immediately, no bvalid; awready=1 one cycle after release.

Source files
------------

// File: rtl/axi4_slave_wr_ctrl.sv
// AXI4 slave write-channel controller: one outstanding burst, per-beat memory write strobe.
// Optional protocol checking (SLVERR on violation) is enabled by defining AXI4_WR_ERR_CHECK_EN.
module axi4_slave_wr_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [3:0]                 awid,
  input  logic [ADDRESS_WIDTH-1:0]   awaddr,
  input  logic [3:0]                 awlen,
  input  logic [2:0]                 awsize,
  input  logic [1:0]                 awburst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic                       wlast,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [3:0]                 bid,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic                       mem_we,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [DATA_WIDTH/8-1:0]    mem_wstrb
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                     state;
  logic [3:0]                 id_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [3:0]                 len_q;
  logic [2:0]                 size_q;
  logic [1:0]                 burst_q;
  logic [3:0]                 cnt_q;
  logic                       aw_hs;
  logic                       w_hs;
  logic [ADDRESS_WIDTH-1:0]   incr;
  logic [ADDRESS_WIDTH-1:0]   wrap_mask;
  logic [ADDRESS_WIDTH-1:0]   next_addr;
  logic [1:0]                 final_resp;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // WRAP region is (len+1) beats of 2^size bytes; the mask keeps the upper address bits fixed.
  always_comb begin
    incr      = ADDRESS_WIDTH'(1) << size_q;
    wrap_mask = (ADDRESS_WIDTH'(5'({1'b0, len_q}) + 5'd1) << size_q) - ADDRESS_WIDTH'(1);
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: next_addr = addr_q + incr;
    endcase
  end

`ifdef AXI4_WR_ERR_CHECK_EN
  logic err_q;
  logic beat_err;
  logic aw_err;

  assign beat_err   = wlast != (cnt_q == 4'd0);
  assign aw_err     = (awburst == 2'b11) || ((8'd1 << awsize) > 8'(STRB_W));
  // The final beat's own wlast check must reach bresp in the same cycle it is registered.
  assign final_resp = (err_q || beat_err) ? 2'b10 : 2'b00;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      err_q <= 1'b0;
    else if (aw_hs)
      err_q <= aw_err;
    else if (w_hs && beat_err)
      err_q <= 1'b1;
  end
`else
  logic unused_wlast;
  assign unused_wlast = wlast;
  assign final_resp   = 2'b00;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q    <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            cnt_q   <= awlen;
            awready <= 1'b0;
            wready  <= 1'b1;
            state   <= DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (cnt_q == 4'd0) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= final_resp;
              state  <= RESP;
            end else begin
              cnt_q  <= cnt_q - 4'd1;
              addr_q <= next_addr;
            end
          end
        end
        RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we    = w_hs;
  assign mem_addr  = w_hs ? addr_q : '0;
  assign mem_wdata = w_hs ? wdata  : '0;
  assign mem_wstrb = w_hs ? wstrb  : '0;

endmodule

// File: tb/tb_axi4_slave_wr_ctrl.sv
// Directed self-checking bench for axi4_slave_wr_ctrl; error-response cases compile in
// only when AXI4_WR_ERR_CHECK_EN is defined.
module tb_axi4_slave_wr_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef AXI4_WR_ERR_CHECK_EN
  localparam logic [1:0] RSV_RESP = 2'b10;
`else
  localparam logic [1:0] RSV_RESP = 2'b00;
`endif

  axi4_slave_wr_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int unsigned waited = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && waited < 20) begin
      tick();
      waited++;
    end
    chk("aw_wait", awready, 1);
    tick();
    awvalid = 1'b0;
    chk("aw_awready_low", awready, 0);
    chk("aw_wready_high", wready, 1);
  endtask

  task automatic beat(input string tag, input logic [31:0] exp_addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic last);
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    #1;
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_data"}, mem_wdata, data);
    chk({tag, "_strb"}, mem_wstrb, strb);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic gap(input string tag);
    #1;
    chk({tag, "_gap_we"}, mem_we, 0);
    chk({tag, "_gap_addr"}, mem_addr, 0);
    tick();
  endtask

  task automatic resp(input string tag, input logic [3:0] id, input logic [1:0] r, input int hold);
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bid"}, bid, id);
    chk({tag, "_bresp"}, bresp, r);
    chk({tag, "_wready_low"}, wready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_bvalid_hold"}, bvalid, 1);
      chk({tag, "_bresp_hold"}, bresp, r);
      chk({tag, "_awready_hold"}, awready, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, bvalid, 0);
    chk({tag, "_idle_awready"}, awready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // reset state, with W activity that must not reach memory
    #2;
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    wvalid = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    #1;
    chk("rel_awready_before_edge", awready, 0);
    tick();
    chk("rel_awready", awready, 1);

    // W in IDLE is ignored
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
    #1;
    chk("idle_w_we", mem_we, 0);
    chk("idle_w_wready", wready, 0);
    wvalid = 1'b0;
    tick();

    // single-beat INCR
    send_aw(4'd3, 32'h0000_0100, 4'd0, 3'd2, 2'b01);
    beat("single", 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1);
    resp("single", 4'd3, 2'b00, 0);

    // INCR 4 beats
    send_aw(4'd5, 32'h0000_1000, 4'd3, 3'd2, 2'b01);
    beat("incr0", 32'h0000_1000, 32'h1111_0000, 4'hF, 1'b0);
    beat("incr1", 32'h0000_1004, 32'h1111_0001, 4'h3, 1'b0);
    beat("incr2", 32'h0000_1008, 32'h1111_0002, 4'hC, 1'b0);
    beat("incr3", 32'h0000_100C, 32'h1111_0003, 4'hF, 1'b1);
    resp("incr", 4'd5, 2'b00, 1);

    // WRAP 4 beats
    send_aw(4'd9, 32'h0000_1008, 4'd3, 3'd2, 2'b10);
    beat("wrap0", 32'h0000_1008, 32'h2222_0000, 4'hF, 1'b0);
    beat("wrap1", 32'h0000_100C, 32'h2222_0001, 4'hF, 1'b0);
    beat("wrap2", 32'h0000_1000, 32'h2222_0002, 4'hF, 1'b0);
    beat("wrap3", 32'h0000_1004, 32'h2222_0003, 4'hF, 1'b1);
    resp("wrap", 4'd9, 2'b00, 0);

    // FIXED with W gaps and B backpressure
    send_aw(4'd12, 32'h0000_0040, 4'd2, 3'd2, 2'b00);
    beat("fixed0", 32'h0000_0040, 32'hA0A0_0000, 4'hF, 1'b0);
    gap("fixed0");
    beat("fixed1", 32'h0000_0040, 32'hA0A0_0001, 4'h1, 1'b0);
    gap("fixed1");
    beat("fixed2", 32'h0000_0040, 32'hA0A0_0002, 4'h8, 1'b1);
    resp("fixed", 4'd12, 2'b00, 5);

    // INCR wraps modulo 2^32
    send_aw(4'd1, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01);
    beat("incr_wrap0", 32'hFFFF_FFFC, 32'h3333_0000, 4'hF, 1'b0);
    beat("incr_wrap1", 32'h0000_0000, 32'h3333_0001, 4'hF, 1'b1);
    resp("incr_wrap", 4'd1, 2'b00, 0);

    // reserved burst behaves as INCR (byte size)
    send_aw(4'd7, 32'h0000_0200, 4'd1, 3'd0, 2'b11);
    beat("rsv0", 32'h0000_0200, 32'h4444_0000, 4'h1, 1'b0);
    beat("rsv1", 32'h0000_0201, 32'h4444_0001, 4'h2, 1'b1);
    resp("rsv", 4'd7, RSV_RESP, 0);

`ifdef AXI4_WR_ERR_CHECK_EN
    // early wlast still yields 4 writes and SLVERR; next clean burst is OKAY
    send_aw(4'd2, 32'h0000_0500, 4'd3, 3'd2, 2'b01);
    beat("err0", 32'h0000_0500, 32'h5555_0000, 4'hF, 1'b0);
    beat("err1", 32'h0000_0504, 32'h5555_0001, 4'hF, 1'b1);
    beat("err2", 32'h0000_0508, 32'h5555_0002, 4'hF, 1'b0);
    beat("err3", 32'h0000_050C, 32'h5555_0003, 4'hF, 1'b0);
    resp("err", 4'd2, 2'b10, 0);
    send_aw(4'd4, 32'h0000_0600, 4'd1, 3'd2, 2'b01);
    beat("clean0", 32'h0000_0600, 32'h6666_0000, 4'hF, 1'b0);
    beat("clean1", 32'h0000_0604, 32'h6666_0001, 4'hF, 1'b1);
    resp("clean", 4'd4, 2'b00, 0);
`endif

    // reset during beat 2 of an 8-beat burst
    send_aw(4'd6, 32'h0000_3000, 4'd7, 3'd2, 2'b01);
    beat("abort0", 32'h0000_3000, 32'h7777_0000, 4'hF, 1'b0);
    beat("abort1", 32'h0000_3004, 32'h7777_0001, 4'hF, 1'b0);
    wdata = 32'h7777_0002; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    chk("abort2_we", mem_we, 1);
    chk("abort2_addr", mem_addr, 32'h0000_3008);
    areset = 1'b1;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_mem_wstrb", mem_wstrb, 0);
    chk("abort_wready", wready, 0);
    chk("abort_awready", awready, 0);
    chk("abort_bvalid", bvalid, 0);
    wvalid = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    #1;
    chk("abort_rel_awready_before", awready, 0);
    tick();
    chk("abort_rel_awready", awready, 1);
    chk("abort_rel_bvalid", bvalid, 0);
    tick();
    chk("abort_no_bvalid", bvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
